// File: rtl/rv_run_pkg.sv
// rv_run_pkg: shared state/status encodings and default tohost constants for the run monitor
package rv_run_pkg;
  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;
  typedef enum logic [2:0] {
    ST_RUNNING = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } status_t;
  localparam logic [5:0]  DEF_TOHOST_ADDR = 6'h3F;
  localparam logic [63:0] DEF_PASS_VALUE  = 64'd1;
endpackage

// File: rtl/rv_stall_detector.sv
// rv_stall_detector: counts consecutive enabled cycles with an unchanged fetch address and flags a hang
module rv_stall_detector #(
  parameter int ADDR_W       = 6,
  parameter int STALL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic              hang
);
  localparam int SW = STALL_CYCLES < 2 ? 1 : $clog2(STALL_CYCLES + 1);
  logic [ADDR_W-1:0] prev;
  logic [SW-1:0]     cnt, cnt_nx;
  // updated stall count and hang flag for the current cycle
  always_comb begin
    cnt_nx = (!en || addr != prev) ? '0 : (&cnt ? cnt : cnt + 1'b1);
    hang   = (STALL_CYCLES != 0) && en && (cnt_nx == SW'(STALL_CYCLES));
  end
  // previous address is sampled every cycle so the first run cycle sees the last hold value
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      cnt  <= '0;
    end else begin
      prev <= addr;
      cnt  <= cnt_nx;
    end
  end
endmodule

// File: rtl/rv_run_monitor.sv
// rv_run_monitor: sequences core reset, watches memory buses and latches the run verdict and statistics
module rv_run_monitor
  import rv_run_pkg::*;
#(
  parameter int                ADDR_W       = 6,
  parameter int                DATA_W       = 64,
  parameter int                CNT_W        = 32,
  parameter int                RESET_CYCLES = 5,
  parameter int                MAX_CYCLES   = 135,
  parameter int                STALL_CYCLES = 16,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = DEF_TOHOST_ADDR,
  parameter logic [DATA_W-1:0] PASS_VALUE   = DEF_PASS_VALUE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              dut_rst_n,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic              d_mem_we,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_data,
  output logic              done,
  output logic              pass,
  output logic [2:0]        status,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  store_count,
  output logic [DATA_W-1:0] result_data
);
  localparam int HW = RESET_CYCLES < 2 ? 1 : $clog2(RESET_CYCLES);
  state_t            state, state_nx;
  status_t           st, st_nx;
  logic [HW-1:0]     hold, hold_nx;
  logic              rst_nx, done_nx, pass_nx, hang, tohost, timeout, pass_val;
  logic [CNT_W-1:0]  cyc_inc, sto_inc, cyc_nx, sto_nx;
  logic [DATA_W-1:0] res_nx;
  rv_stall_detector #(.ADDR_W(ADDR_W), .STALL_CYCLES(STALL_CYCLES)) u_stall (
    .clk  (clk),
    .reset(reset),
    .en   (state == RUN),
    .addr (i_mem_addr),
    .hang (hang)
  );
  assign status = st;
  // next-state logic: hold sequencing, run accounting with tohost > timeout > hang priority, re-arm from done
  always_comb begin
    cyc_inc  = &cycle_count ? cycle_count : cycle_count + 1'b1;
    sto_inc  = &store_count ? store_count : store_count + 1'b1;
    tohost   = d_mem_we && d_mem_addr == TOHOST_ADDR;
    timeout  = cyc_inc == CNT_W'(MAX_CYCLES);
    pass_val = d_mem_data == PASS_VALUE;
    state_nx = state;
    hold_nx  = hold;
    rst_nx   = dut_rst_n;
    done_nx  = done;
    pass_nx  = pass;
    st_nx    = st;
    cyc_nx   = cycle_count;
    sto_nx   = store_count;
    res_nx   = result_data;
    case (state)
      HOLD: begin
        hold_nx = hold == HW'(RESET_CYCLES - 1) ? '0 : hold + 1'b1;
        if (hold == HW'(RESET_CYCLES - 1)) begin
          state_nx = RUN;
          rst_nx   = 1'b1;
        end
      end
      RUN: begin
        cyc_nx = cyc_inc;
        sto_nx = d_mem_we ? sto_inc : store_count;
        if (tohost || timeout || hang) begin
          state_nx = DONE;
          rst_nx   = 1'b0;
          done_nx  = 1'b1;
        end
        if (tohost) begin
          res_nx  = d_mem_data;
          st_nx   = pass_val ? ST_PASS : ST_FAIL;
          pass_nx = pass_val;
        end else if (timeout) begin
          st_nx = ST_TIMEOUT;
        end else if (hang) begin
          st_nx = ST_HANG;
        end
      end
      DONE: begin
        if (start) begin
          state_nx = HOLD;
          hold_nx  = '0;
          done_nx  = 1'b0;
          pass_nx  = 1'b0;
          st_nx    = ST_RUNNING;
          cyc_nx   = '0;
          sto_nx   = '0;
          res_nx   = '0;
        end
      end
      default: state_nx = HOLD;
    endcase
  end
  // state and registered outputs; reset aborts any run and re-enters hold
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      hold        <= '0;
      dut_rst_n   <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      st          <= ST_RUNNING;
      cycle_count <= '0;
      store_count <= '0;
      result_data <= '0;
    end else begin
      state       <= state_nx;
      hold        <= hold_nx;
      dut_rst_n   <= rst_nx;
      done        <= done_nx;
      pass        <= pass_nx;
      st          <= st_nx;
      cycle_count <= cyc_nx;
      store_count <= sto_nx;
      result_data <= res_nx;
    end
  end
endmodule

// File: tb/tb_rv_run_monitor.sv
// tb_rv_run_monitor: scoreboard bench driving two monitors (default and hang check disabled) with shared stimulus
module tb_rv_run_monitor;
  typedef struct {
    logic [2:0]  st;
    logic [31:0] cyc;
    logic [31:0] sto;
    logic [63:0] data;
  } exp_t;
  logic        clk = 0, reset = 1, start = 0, d_mem_we = 0;
  logic [5:0]  i_mem_addr = 0, d_mem_addr = 0;
  logic [63:0] d_mem_data = 0;
  logic        dut_rst_n_a, done_a, pass_a, dut_rst_n_b, done_b, pass_b;
  logic [2:0]  status_a, status_b;
  logic [31:0] cycle_count_a, store_count_a, cycle_count_b, store_count_b;
  logic [63:0] result_data_a, result_data_b;
  int          errors = 0, checks = 0;
  exp_t        qa[$], qb[$];
  exp_t        last_a;
  always #5 clk = ~clk;
  rv_run_monitor dut_a (
    .clk(clk), .reset(reset), .start(start), .dut_rst_n(dut_rst_n_a),
    .i_mem_addr(i_mem_addr), .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr), .d_mem_data(d_mem_data),
    .done(done_a), .pass(pass_a), .status(status_a), .cycle_count(cycle_count_a),
    .store_count(store_count_a), .result_data(result_data_a)
  );
  rv_run_monitor #(.STALL_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .dut_rst_n(dut_rst_n_b),
    .i_mem_addr(i_mem_addr), .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr), .d_mem_data(d_mem_data),
    .done(done_b), .pass(pass_b), .status(status_b), .cycle_count(cycle_count_b),
    .store_count(store_count_b), .result_data(result_data_b)
  );
  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic exp_t mk(logic [2:0] st, logic [31:0] cyc, logic [31:0] sto, logic [63:0] data);
    exp_t e;
    e.st = st; e.cyc = cyc; e.sto = sto; e.data = data;
    return e;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    start = 0; d_mem_we = 0; d_mem_addr = 0; d_mem_data = 0; i_mem_addr = 0;
  endtask
  task automatic check_cleared(string tag);
    check({tag, "_rstn_a"}, dut_rst_n_a, 0);
    check({tag, "_done_a"}, done_a, 0);
    check({tag, "_pass_a"}, pass_a, 0);
    check({tag, "_status_a"}, status_a, 0);
    check({tag, "_cyc_a"}, cycle_count_a, 0);
    check({tag, "_sto_a"}, store_count_a, 0);
    check({tag, "_res_a"}, result_data_a, 0);
    check({tag, "_done_b"}, done_b, 0);
    check({tag, "_cyc_b"}, cycle_count_b, 0);
  endtask
  task automatic do_hold(string tag);
    for (int i = 0; i < 5; i++) begin
      check({tag, "_hold_rstn_a"}, dut_rst_n_a, 0);
      check({tag, "_hold_rstn_b"}, dut_rst_n_b, 0);
      check({tag, "_hold_status"}, status_a, 0);
      step();
    end
    check({tag, "_run_rstn_a"}, dut_rst_n_a, 1);
    check({tag, "_run_rstn_b"}, dut_rst_n_b, 1);
    check({tag, "_run_status"}, status_a, 0);
  endtask
  task automatic sb_cmp(string tag, exp_t e, logic [2:0] st, logic ps, logic [31:0] cc,
                        logic [31:0] sc, logic [63:0] rd);
    check({tag, "_status"}, st, e.st);
    check({tag, "_pass"}, ps, e.st == 3'd1);
    check({tag, "_cycles"}, cc, e.cyc);
    check({tag, "_stores"}, sc, e.sto);
    check({tag, "_result"}, rd, e.data);
  endtask
  task automatic run_prog(string tag, int th_at, logic [63:0] th_data, int freeze_at, int rst_at);
    bit   fa = 0, fb = 0;
    int   k = 0;
    exp_t e;
    while (!(fa && fb) && k < 200) begin
      k++;
      i_mem_addr = (freeze_at != 0 && k >= freeze_at) ? 6'h08 : 6'(k);
      d_mem_we   = (k == 10 || k == 20 || k == th_at);
      d_mem_addr = (k == th_at) ? 6'h3F : 6'h04;
      d_mem_data = (k == th_at) ? th_data : 64'hDEAD;
      start      = (k == 15);
      reset      = (k == rst_at);
      step();
      if (k == rst_at) break;
      if (done_a && !fa) begin
        fa = 1;
        if (qa.size() == 0) check({tag, "_sb_empty_a"}, 1, 0);
        else begin
          e = qa.pop_front();
          last_a = e;
          sb_cmp({tag, "_a"}, e, status_a, pass_a, cycle_count_a, store_count_a, result_data_a);
        end
      end
      if (done_b && !fb) begin
        fb = 1;
        if (qb.size() == 0) check({tag, "_sb_empty_b"}, 1, 0);
        else begin
          e = qb.pop_front();
          sb_cmp({tag, "_b"}, e, status_b, pass_b, cycle_count_b, store_count_b, result_data_b);
        end
      end
    end
    start = 0; d_mem_we = 0; d_mem_addr = 0; d_mem_data = 0; i_mem_addr = 0;
    if (rst_at == 0 && !(fa && fb)) check({tag, "_run_bound"}, 0, 1);
  endtask
  task automatic done_phase(string tag);
    d_mem_we = 1; d_mem_addr = 6'h3F; d_mem_data = 64'd1;
    step();
    step();
    check({tag, "_done_held"}, done_a, 1);
    check({tag, "_done_rstn"}, dut_rst_n_a, 0);
    check({tag, "_done_cyc"}, cycle_count_a, last_a.cyc);
    check({tag, "_done_sto"}, store_count_a, last_a.sto);
    idle_inputs();
    start = 1;
    step();
    start = 0;
    check_cleared({tag, "_restart"});
    do_hold({tag, "_rearm"});
  endtask
  initial begin
    reset = 1;
    idle_inputs();
    repeat (3) step();
    check_cleared("reset");
    reset = 0;
    do_hold("init");
    qa.push_back(mk(3'd1, 32'd40, 32'd3, 64'd1));
    qb.push_back(mk(3'd1, 32'd40, 32'd3, 64'd1));
    run_prog("pass", 40, 64'd1, 0, 0);
    done_phase("pass");
    qa.push_back(mk(3'd2, 32'd40, 32'd3, 64'h2A));
    qb.push_back(mk(3'd2, 32'd40, 32'd3, 64'h2A));
    run_prog("fail", 40, 64'h2A, 0, 0);
    done_phase("fail");
    qa.push_back(mk(3'd3, 32'd135, 32'd2, 64'd0));
    qb.push_back(mk(3'd3, 32'd135, 32'd2, 64'd0));
    run_prog("timeout", 0, 64'd0, 0, 0);
    done_phase("timeout");
    qa.push_back(mk(3'd1, 32'd135, 32'd3, 64'd1));
    qb.push_back(mk(3'd1, 32'd135, 32'd3, 64'd1));
    run_prog("tohost_last", 135, 64'd1, 0, 0);
    done_phase("tohost_last");
    qa.push_back(mk(3'd4, 32'd21, 32'd2, 64'd0));
    qb.push_back(mk(3'd3, 32'd135, 32'd2, 64'd0));
    run_prog("hang", 0, 64'd0, 5, 0);
    done_phase("hang");
    run_prog("midrun", 0, 64'd0, 0, 30);
    check_cleared("midrun");
    reset = 0;
    do_hold("after_reset");
    check("sb_leftover", qa.size() + qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv_run_monitor.md
Name: rv_run_monitor

Overview:
- Parametrised, synthesizable run controller and self-check monitor for the polirv core and its external memory.
- Generates the core's reset sequence, then watches the instruction and data memory buses until the program ends.
- The program ends by a tohost store, a cycle timeout, or a fetch-address hang. On exit it latches a pass/fail verdict and statistics.
- Replaces hard-coded reset/run delays in benches; also usable on FPGA, with status driving LEDs.

Parameters:
- ADDR_W, 6: width of i_mem_addr and d_mem_addr.
- DATA_W, 64: width of d_mem_data.
- CNT_W, 32: width of cycle_count and store_count.
- RESET_CYCLES, 5: cycles dut_rst_n is held low after the monitor leaves reset; must be ≥1.
- MAX_CYCLES, 135: RUN-cycle budget before TIMEOUT; must be ≥1.
- STALL_CYCLES, 16: consecutive RUN cycles with an unchanged i_mem_addr that flag HANG; 0 disables the check.
- TOHOST_ADDR, 6'h3F: data address whose store terminates the run.
- PASS_VALUE, 64'd1: tohost data value meaning pass.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset of this block.
- start, input, 1: single-cycle pulse; re-arms the run from DONE.
- dut_rst_n, output, 1: active-low reset to the polirv core (its rst_n).
- i_mem_addr, input, ADDR_W: core fetch address (observed only).
- d_mem_we, input, 1: core data write enable (observed only).
- d_mem_addr, input, ADDR_W: core data address (observed only).
- d_mem_data, input, DATA_W: core data bus (observed only).
- done, output, 1: high while in DONE.
- pass, output, 1: high in DONE when status == PASS.
- status, output, 3: 0 RUNNING, 1 PASS, 2 FAIL, 3 TIMEOUT, 4 HANG.
- cycle_count, output, CNT_W: number of RUN cycles elapsed.
- store_count, output, CNT_W: number of RUN cycles with d_mem_we = 1.
- result_data, output, DATA_W: data captured from the tohost store.

Behaviour:
- States: HOLD, RUN, DONE. All outputs are registered.
- Reset (synchronous, active-high):
  - state = HOLD, hold counter = 0, dut_rst_n = 0, done = 0, pass = 0, status = 0.
  - cycle_count, store_count, result_data and the stall counter = 0.
  - Reset asserted in any state, including mid-RUN, aborts the run immediately with these values.
- HOLD:
  - The hold counter increments each cycle.
  - On the cycle it reaches RESET_CYCLES-1, the state moves to RUN and dut_rst_n goes to 1 on the next edge.
  - Net effect: dut_rst_n stays low for exactly RESET_CYCLES cycles after reset deasserts.
- RUN, evaluated every cycle:
  - cycle_count += 1.
  - If d_mem_we = 1, store_count += 1.
  - Stall counter: increments if i_mem_addr equals the previous-cycle value, otherwise clears.
  - The first RUN cycle compares against the value sampled in the last HOLD cycle.
- Termination, evaluated every RUN cycle with priority tohost > timeout > hang. The chosen result is registered into DONE on the next edge:
  - Tohost: d_mem_we = 1 and d_mem_addr == TOHOST_ADDR. result_data = d_mem_data; status = PASS if the data equals PASS_VALUE, else FAIL.
  - Timeout: the updated cycle_count equals MAX_CYCLES. status = TIMEOUT, so the final cycle_count is MAX_CYCLES.
  - Hang: STALL_CYCLES != 0 and the updated stall counter equals STALL_CYCLES. status = HANG.
  - A tohost store on the same cycle as a timeout still yields PASS or FAIL; it is included in both counters.
- DONE:
  - dut_rst_n = 0, freezing the core; done = 1; all counters and result_data hold.
  - start = 1 returns to HOLD, clears all counters, result_data and status, and deasserts done/pass on the next edge.
  - start is ignored in HOLD and RUN.
- Counters saturate at all-ones and never wrap.
- d_mem_addr and d_mem_data are ignored while d_mem_we = 0. Stores in HOLD or DONE are not counted.

Decomposition:
- Package rv_run_pkg:
  - state encoding HOLD/RUN/DONE;
  - status codes ST_RUNNING/ST_PASS/ST_FAIL/ST_TIMEOUT/ST_HANG, 3 bits;
  - default TOHOST_ADDR and PASS_VALUE constants.
- One sub-module: rv_stall_detector. It holds the previous-address register and the saturating stall counter, and outputs a hang flag; parameters ADDR_W and STALL_CYCLES.

Test Plan:
- Reset high for 3 cycles, then low → dut_rst_n = 0 for exactly 5 cycles, rising on cycle 6; status = 0 throughout.
- In RUN, incrementing fetch addresses, stores to 0x04 at RUN cycles 10 and 20, then we = 1, addr = 0x3F, data = 1 at RUN cycle 40 → done at cycle 41, pass = 1, status = 1, cycle_count = 40, store_count = 3, result_data = 1.
- Same as above but tohost data = 0x2A → status = 2, pass = 0, result_data = 0x2A.
- No tohost store, fetch address keeps changing → status = 3 with cycle_count = 135. A tohost store at RUN cycle 135 instead → status = 1.
- Fetch address frozen at 0x08 from RUN cycle 5 → status = 4 once 16 consecutive unchanged cycles elapse. With STALL_CYCLES = 0, the same stimulus → TIMEOUT.
- Reset pulsed at RUN cycle 30 → all outputs zero next cycle and HOLD restarts. In DONE, a start pulse → counters cleared and a fresh 5-cycle hold follows.
